// File: rtl/ocra1_serialiser_pkg.sv
// Shared OCRA1 link definitions: AD5781 frame layout, register addresses and transmitter FSM states.
// Imported by the serialiser, its interface and anything that builds AD5781 frames.
package ocra1_serialiser_pkg;

  localparam int FRAME_W = 24;
  localparam int N_CH    = 4;
  localparam int BIT_W   = 5;
  localparam logic [BIT_W-1:0] BIT_MSB = 5'd23;

  localparam logic [2:0] ADDR_DAC     = 3'b001;
  localparam logic [2:0] ADDR_CTRL    = 3'b010;
  localparam logic [2:0] ADDR_CLRCODE = 3'b011;
  localparam logic [2:0] ADDR_SWCTRL  = 3'b100;

  typedef struct packed {
    logic        rw;
    logic [2:0]  addr;
    logic [19:0] data;
  } frame_t;

  // Lane 0 = x, 1 = y, 2 = z, 3 = z2.
  typedef logic [N_CH-1:0][FRAME_W-1:0] lanes_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP,
    ST_LDAC
  } state_t;

  function automatic frame_t ad5781_frame(input logic rw, input logic [2:0] addr,
                                          input logic [19:0] data);
    frame_t f;
    f.rw   = rw;
    f.addr = addr;
    f.data = data;
    return f;
  endfunction

  // Counter width able to hold 0..max_count-1, never narrower than one bit.
  function automatic int cnt_w(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/ocra1_serialiser_if.sv
// Frame-set handshake from the gradient-update logic plus the ocra1_* pin bundle.
// master = upstream/bench side, slave = serialiser side.
interface ocra1_serialiser_if;
  import ocra1_serialiser_pkg::*;

  frame_t datax;
  frame_t datay;
  frame_t dataz;
  frame_t dataz2;
  logic   ldac;
  logic   valid;
  logic   ready;
  logic   busy;
  logic   ocra1_clk;
  logic   ocra1_syncn;
  logic   ocra1_ldacn;
  logic   ocra1_sdox;
  logic   ocra1_sdoy;
  logic   ocra1_sdoz;
  logic   ocra1_sdoz2;

  modport master (
    output datax, datay, dataz, dataz2, ldac, valid,
    input  ready, busy, ocra1_clk, ocra1_syncn, ocra1_ldacn,
           ocra1_sdox, ocra1_sdoy, ocra1_sdoz, ocra1_sdoz2
  );

  modport slave (
    input  datax, datay, dataz, dataz2, ldac, valid,
    output ready, busy, ocra1_clk, ocra1_syncn, ocra1_ldacn,
           ocra1_sdox, ocra1_sdoy, ocra1_sdoz, ocra1_sdoz2
  );

endinterface

// File: rtl/ocra1_serialiser_tick_gen.sv
// Half-period divider: tick high on the last cycle of every CLK_DIV-cycle slot; clear restarts the slot.
// Zero latency from counter to tick; no flow control.
module ocra1_serialiser_tick_gen
  import ocra1_serialiser_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ocra1_serialiser.sv
// OCRA1 transmitter: four AD5781 frames MSB-first on shared SCLK/SYNCn, then optional LDACn pulse.
// Ready again 1+52*CLK_DIV (+LDAC_W) cycles after accept; valid is ignored while busy (upstream holds it).
module ocra1_serialiser
  import ocra1_serialiser_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int LDAC_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  ocra1_serialiser_if.slave bus
);
  localparam int LW = cnt_w(LDAC_W);
  localparam logic [LW-1:0] LDAC_LAST = LW'(LDAC_W - 1);

  state_t          state, state_nxt;
  lanes_t          frm, frm_nxt;
  logic            ldac_q, ldac_nxt;
  logic            half, half_nxt;
  logic [BIT_W-1:0] bit_idx, bit_nxt;
  logic [LW-1:0]   lcnt, lcnt_nxt;
  logic            tick;
  logic            active;
  logic            ready_d, sclk_d, syncn_d, ldacn_d;
  logic [N_CH-1:0] sdo_d;

  // Every state entry restarts the divider so each phase begins on a slot boundary.
  ocra1_serialiser_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state_nxt != state),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      frm     <= '0;
      ldac_q  <= 1'b0;
      half    <= 1'b0;
      bit_idx <= '0;
      lcnt    <= '0;
    end else begin
      state   <= state_nxt;
      frm     <= frm_nxt;
      ldac_q  <= ldac_nxt;
      half    <= half_nxt;
      bit_idx <= bit_nxt;
      lcnt    <= lcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    frm_nxt   = frm;
    ldac_nxt  = ldac_q;
    half_nxt  = half;
    bit_nxt   = bit_idx;
    lcnt_nxt  = lcnt;
    unique case (state)
      ST_IDLE: begin
        if (bus.valid) begin
          state_nxt = ST_SETUP;
          frm_nxt   = {bus.dataz2, bus.dataz, bus.datay, bus.datax};
          ldac_nxt  = bus.ldac;
          bit_nxt   = BIT_MSB;
        end
      end
      ST_SETUP: begin
        if (tick) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        // half=0: SCLK high slot, half=1: SCLK low slot; bit advances at the end of the low slot.
        if (tick) begin
          half_nxt = ~half;
          if (half) begin
            if (bit_idx == '0) state_nxt = ST_HOLD;
            else               bit_nxt   = bit_idx - 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (tick) begin
          half_nxt = ~half;
          if (half) state_nxt = ldac_q ? ST_LDAC : ST_IDLE;
        end
      end
      ST_LDAC: begin
        if (lcnt == LDAC_LAST) state_nxt = ST_IDLE;
        else                   lcnt_nxt  = lcnt + 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state_nxt != state) begin
      half_nxt = 1'b0;
      lcnt_nxt = '0;
    end
  end

  // Pin values are decoded from next-state and registered, so pins line up with the state they describe.
  always_comb begin
    active  = state_nxt inside {ST_SETUP, ST_SHIFT, ST_HOLD};
    ready_d = (state_nxt == ST_IDLE);
    syncn_d = ~active;
    sclk_d  = (state_nxt == ST_SHIFT) && !half_nxt;
    ldacn_d = (state_nxt != ST_LDAC);
    sdo_d   = '0;
    for (int c = 0; c < N_CH; c++) begin
      sdo_d[c] = active & frm_nxt[c][bit_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ready       <= 1'b1;
      bus.busy        <= 1'b0;
      bus.ocra1_clk   <= 1'b0;
      bus.ocra1_syncn <= 1'b1;
      bus.ocra1_ldacn <= 1'b1;
      bus.ocra1_sdox  <= 1'b0;
      bus.ocra1_sdoy  <= 1'b0;
      bus.ocra1_sdoz  <= 1'b0;
      bus.ocra1_sdoz2 <= 1'b0;
    end else begin
      bus.ready       <= ready_d;
      bus.busy        <= ~ready_d;
      bus.ocra1_clk   <= sclk_d;
      bus.ocra1_syncn <= syncn_d;
      bus.ocra1_ldacn <= ldacn_d;
      bus.ocra1_sdox  <= sdo_d[0];
      bus.ocra1_sdoy  <= sdo_d[1];
      bus.ocra1_sdoz  <= sdo_d[2];
      bus.ocra1_sdoz2 <= sdo_d[3];
    end
  end

endmodule

// File: tb/tb_ocra1_serialiser.sv
// Bench: two serialisers (CLK_DIV=2 and CLK_DIV=1) driven with directed and random frame sets,
// observed through a bench-side AD5781 receiver and checked against timing derived from the phase lengths.
module tb_ocra1_serialiser;
  import ocra1_serialiser_pkg::*;

  localparam int DA = 2;
  localparam int DB = 1;
  localparam int LW = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ocra1_serialiser_if bus_a ();
  ocra1_serialiser_if bus_b ();

  ocra1_serialiser #(.CLK_DIV(DA), .LDAC_W(LW)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  ocra1_serialiser #(.CLK_DIV(DB), .LDAC_W(LW)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic       sclk_s [2], syncn_s [2], ldacn_s [2], ready_s [2], busy_s [2];
  logic [3:0] sdo_s  [2];
  assign sclk_s[0]  = bus_a.ocra1_clk;    assign sclk_s[1]  = bus_b.ocra1_clk;
  assign syncn_s[0] = bus_a.ocra1_syncn;  assign syncn_s[1] = bus_b.ocra1_syncn;
  assign ldacn_s[0] = bus_a.ocra1_ldacn;  assign ldacn_s[1] = bus_b.ocra1_ldacn;
  assign ready_s[0] = bus_a.ready;        assign ready_s[1] = bus_b.ready;
  assign busy_s[0]  = bus_a.busy;         assign busy_s[1]  = bus_b.busy;
  assign sdo_s[0] = {bus_a.ocra1_sdoz2, bus_a.ocra1_sdoz, bus_a.ocra1_sdoy, bus_a.ocra1_sdox};
  assign sdo_s[1] = {bus_b.ocra1_sdoz2, bus_b.ocra1_sdoz, bus_b.ocra1_sdoy, bus_b.ocra1_sdox};

  // Receiver model: shift on SCLK falls while SYNCn low, keep a word only if 24 bits arrived,
  // copy input register to vout on the LDACn falling edge.
  logic [95:0] shreg [2] = '{default: '0};
  logic [95:0] inreg [2] = '{default: '0};
  logic [95:0] vout  [2] = '{default: '0};
  logic [95:0] got_a [$];
  logic [95:0] got_b [$];
  int   nbit [2] = '{0, 0};
  int   falls [2] = '{0, 0};
  int   n_lfall [2] = '{0, 0};
  int   t_sfall [2] = '{0, 0};
  int   t_srise [2] = '{0, 0};
  int   t_rise1 [2] = '{-1, -1};
  int   t_lfall [2] = '{0, 0};
  int   t_lrise [2] = '{0, 0};
  logic p_sclk [2] = '{1'b0, 1'b0};
  logic p_syncn [2] = '{1'b1, 1'b1};
  logic p_ldacn [2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        if (p_syncn[k] && !syncn_s[k]) begin
          t_sfall[k] = cyc;
          t_rise1[k] = -1;
          nbit[k] = 0;
        end
        if (!p_sclk[k] && sclk_s[k] && t_rise1[k] < 0) t_rise1[k] = cyc;
        if (p_sclk[k] && !sclk_s[k] && !syncn_s[k]) begin
          for (int c = 0; c < 4; c++)
            shreg[k][c*24 +: 24] = {shreg[k][c*24 +: 23], sdo_s[k][c]};
          nbit[k]++;
          falls[k]++;
        end
        if (!p_syncn[k] && syncn_s[k]) begin
          t_srise[k] = cyc;
          if (nbit[k] == 24) begin
            inreg[k] = shreg[k];
            if (k == 0) got_a.push_back(shreg[k]);
            else        got_b.push_back(shreg[k]);
          end
          nbit[k] = 0;
        end
        if (p_ldacn[k] && !ldacn_s[k]) begin
          t_lfall[k] = cyc;
          n_lfall[k]++;
          vout[k] = inreg[k];
        end
        if (!p_ldacn[k] && ldacn_s[k]) t_lrise[k] = cyc;
      end
      p_sclk[k]  = sclk_s[k];
      p_syncn[k] = syncn_s[k];
      p_ldacn[k] = ldacn_s[k];
    end
  end

  logic [2:0] addrs [4] = '{ADDR_DAC, ADDR_CTRL, ADDR_CLRCODE, ADDR_SWCTRL};

  function automatic logic [95:0] rand_set();
    logic [95:0] s;
    for (int c = 0; c < 4; c++)
      s[c*24 +: 24] = ad5781_frame(1'($urandom), addrs[$urandom_range(0, 3)], 20'($urandom));
    return s;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? got_a.size() : got_b.size();
  endfunction

  function automatic logic [95:0] got_at(input int k, input int i);
    return (k == 0) ? got_a[i] : got_b[i];
  endfunction

  function automatic logic [8:0] pins(input int k);
    return {sclk_s[k], syncn_s[k], ldacn_s[k], ready_s[k], busy_s[k], sdo_s[k]};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic [95:0] f, input logic l, input logic v);
    if (k == 0) begin
      bus_a.datax = f[23:0];  bus_a.datay = f[47:24];
      bus_a.dataz = f[71:48]; bus_a.dataz2 = f[95:72];
      bus_a.ldac = l; bus_a.valid = v;
    end else begin
      bus_b.datax = f[23:0];  bus_b.datay = f[47:24];
      bus_b.dataz = f[71:48]; bus_b.dataz2 = f[95:72];
      bus_b.ldac = l; bus_b.valid = v;
    end
  endtask

  // Returns t0 = the cycle in which valid and ready were both high.
  task automatic send(input int k, input logic [95:0] f, input logic l, input logic keep,
                      output int t0);
    drive(k, f, l, 1'b1);
    t0 = -1;
    for (int n = 0; n < 400 && t0 < 0; n++) begin
      if (ready_s[k]) t0 = cyc;
      else step();
    end
    chk("accept_seen", 96'(t0 >= 0), 96'(1));
    step();
    if (!keep) drive(k, f, l, 1'b0);
  endtask

  task automatic wait_ready(input int k, output int tr);
    tr = -1;
    for (int n = 0; n < 400 && tr < 0; n++) begin
      step();
      if (ready_s[k]) tr = cyc;
    end
    chk("ready_seen", 96'(tr >= 0), 96'(1));
  endtask

  task automatic run_txn(input int k, input logic [95:0] f, input logic l, input string tag);
    int t0, tr, d, nl0, nq0, f0;
    logic [95:0] v0;
    d = (k == 0) ? DA : DB;
    nl0 = n_lfall[k];
    v0 = vout[k];
    nq0 = qsize(k);
    f0 = falls[k];
    send(k, f, l, 1'b0, t0);
    chk({tag, "_busy"}, 96'({ready_s[k], busy_s[k]}), 96'(2'b01));
    wait_ready(k, tr);
    chk({tag, "_ready_lat"}, tr - t0, 1 + 52 * d + (l ? LW : 0));
    chk({tag, "_syncn_fall"}, t_sfall[k] - t0, 1);
    chk({tag, "_sclk_rise1"}, t_rise1[k] - t0, 1 + d);
    chk({tag, "_syncn_rise"}, t_srise[k] - t0, 1 + 50 * d);
    chk({tag, "_sclk_falls"}, falls[k] - f0, 24);
    chk({tag, "_nframes"}, qsize(k), nq0 + 1);
    chk({tag, "_frame"}, got_at(k, qsize(k) - 1), f);
    if (l) begin
      chk({tag, "_ldacn_low"}, t_lfall[k] - t0, 1 + 52 * d);
      chk({tag, "_ldacn_high"}, t_lrise[k] - t0, 1 + 52 * d + LW);
      chk({tag, "_vout"}, vout[k], f);
    end else begin
      chk({tag, "_no_ldac"}, n_lfall[k], nl0);
      chk({tag, "_vout_held"}, vout[k], v0);
    end
  endtask

  initial begin
    logic [95:0] f1, f2;
    int t0, t1, tr, nq0;
    rst = 1'b1;
    drive(0, '0, 1'b0, 1'b0);
    drive(1, '0, 1'b0, 1'b0);
    repeat (3) step();
    chk("reset_pins_a", pins(0), 9'b0_1_1_1_0_0000);
    chk("reset_pins_b", pins(1), 9'b0_1_1_1_0_0000);
    rst = 1'b0;
    step();

    f1 = {24'h1AAAA8, 24'h000004, 24'h100000, 24'h1FFFFC};
    run_txn(0, f1, 1'b1, "t1");
    run_txn(0, f1, 1'b0, "t2");
    for (int i = 0; i < 4; i++) run_txn(0, rand_set(), 1'($urandom), "rnd");

    // Valid held across two frame sets: second accept in the first ready cycle.
    f1 = rand_set();
    f2 = rand_set();
    nq0 = qsize(0);
    send(0, f1, 1'b0, 1'b1, t0);
    send(0, f2, 1'b0, 1'b0, t1);
    chk("b2b_accept", t1 - t0, 1 + 52 * DA);
    chk("b2b_syncn_high", t_sfall[0] - t_srise[0], 2 * DA + 1);
    wait_ready(0, tr);
    chk("b2b_count", qsize(0), nq0 + 2);
    chk("b2b_first", got_at(0, nq0), f1);
    chk("b2b_second", got_at(0, nq0 + 1), f2);

    // Asynchronous reset in the middle of SHIFT.
    nq0 = qsize(0);
    send(0, rand_set(), 1'b1, 1'b0, t0);
    for (int n = 0; n < 200 && cyc < t0 + 50; n++) step();
    rst = 1'b1;
    #1;
    chk("midrst_pins", pins(0), 9'b0_1_1_1_0_0000);
    step();
    rst = 1'b0;
    step();
    chk("midrst_dropped", qsize(0), nq0);
    chk("midrst_ldacn", ldacn_s[0], 1'b1);
    run_txn(0, rand_set(), 1'b1, "post_rst");

    // Valid pulsed while busy must not disturb the frame in flight.
    f1 = rand_set();
    f2 = ~f1;
    nq0 = qsize(0);
    send(0, f1, 1'b0, 1'b0, t0);
    repeat (20) step();
    drive(0, f2, 1'b1, 1'b1);
    step();
    drive(0, f2, 1'b1, 1'b0);
    wait_ready(0, tr);
    chk("busy_valid_lat", tr - t0, 1 + 52 * DA);
    chk("busy_valid_count", qsize(0), nq0 + 1);
    chk("busy_valid_frame", got_at(0, qsize(0) - 1), f1);

    run_txn(1, {4{24'hA5A5A5}}, 1'b0, "div1_a5");
    run_txn(1, rand_set(), 1'b1, "div1_rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
